// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: computes A - B one bit per clock, LSB first, using a
// single full-subtractor slice and a registered borrow.
//
// Handshake: start is a request that is only sampled in IDLE. The edge that
// samples start=1 captures a/b, and busy rises after that edge. Each RUN edge
// produces one difference bit, which is qualified by a one-cycle diff_valid.
// On the final bit, done pulses for one cycle and diff/borrow_out update;
// they then hold until the next completion.
`timescale 1ns/1ps
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             done,
  output logic             state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] res_q;       // bits already produced, newest at the top
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             busy_q;
  logic             diff_bit_q;
  logic             diff_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;
  logic             done_q;

  logic             slice_x;
  logic             slice_y;
  logic             slice_diff;
  logic             slice_borrow;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-2:0] res_d;
  logic             last_bit;

  // Full-subtractor slice on the operand LSBs plus the result shift path.
  always_comb begin
    slice_x      = a_q[0];
    slice_y      = b_q[0];
    slice_diff   = slice_x ^ slice_y ^ brw_q;
    slice_borrow = (~slice_x & slice_y) | (~(slice_x ^ slice_y) & brw_q);
    // The new bit enters at the MSB, so after WIDTH steps bit 0 sits at the LSB.
    res_full     = {slice_diff, res_q};
    res_d        = res_full[WIDTH-1:1];
    last_bit     = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers. All outputs are registered.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      brw_q        <= 1'b0;
      busy_q       <= 1'b0;
      diff_bit_q   <= 1'b0;
      diff_valid_q <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q       <= 1'b0;
          diff_valid_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          diff_bit_q   <= slice_diff;
          diff_valid_q <= 1'b1;
          res_q        <= res_d;
          a_q          <= a_q >> 1;
          b_q          <= b_q >> 1;
          brw_q        <= slice_borrow;
          cnt_q        <= cnt_q + CW'(1);
          if (last_bit) begin
            // The last bit completes the result; publish it and go idle.
            diff_q       <= res_full;
            borrow_out_q <= slice_borrow;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            state_q      <= IDLE;
          end else begin
            done_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign diff_bit   = diff_bit_q;
  assign diff_valid = diff_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Testbench for bit_serial_subtractor: an 8-bit instance for streaming and
// handshake behaviour and a 4-bit instance for an exhaustive operand sweep.
`timescale 1ns/1ps
module tb_bit_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic CK  = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, diff_bit8, diff_valid8, borrow8, done8, state8;
  logic [7:0] diff8;

  // 4-bit instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, diff_bit4, diff_valid4, borrow4, done4, state4;
  logic [3:0] diff4;

  bit_serial_subtractor #(.WIDTH(8)) dut8 (
    .CK(CK), .RST(RST), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .diff_bit(diff_bit8), .diff_valid(diff_valid8),
    .diff(diff8), .borrow_out(borrow8), .done(done8), .state_dbg(state8)
  );

  bit_serial_subtractor #(.WIDTH(4)) dut4 (
    .CK(CK), .RST(RST), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .diff_bit(diff_bit4), .diff_valid(diff_valid4),
    .diff(diff4), .borrow_out(borrow4), .done(done4), .state_dbg(state4)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [8:0] exp_q[$];   // expected {borrow, diff} per 8-bit operation

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // Reference: unsigned modular difference and borrow = (a < b).
  function automatic logic [8:0] ref_sub8(input int av, input int bv);
    int d;
    d = ((av - bv) + 256) % 256;
    return {(av < bv) ? 1'b1 : 1'b0, 8'(d)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge. Runs one 8-bit operation and checks every streamed
  // bit and the completion. Returns at the negedge of the done cycle, so a
  // following call starts back-to-back. With disturb set, a/b/start are
  // scrambled during RUN, which must have no effect.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit disturb);
    logic [8:0] e;
    exp_q.push_back(ref_sub8(int'(av), int'(bv)));
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge CK);                       // E0 has accepted
    chk("e0_busy", busy8, 1);
    chk("e0_valid", diff_valid8, 0);
    start8 = disturb;
    if (disturb) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
    end
    e = exp_q[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge CK);
      chk($sformatf("bit%0d_valid", i), diff_valid8, 1);
      chk($sformatf("bit%0d_val", i), diff_bit8, e[i]);
      if (i < 7) begin
        chk($sformatf("bit%0d_done", i), done8, 0);
        chk($sformatf("bit%0d_busy", i), busy8, 1);
        if (disturb) begin
          a8 = 8'($urandom_range(0, 255));
          b8 = 8'($urandom_range(0, 255));
          start8 = (i < 6);
        end else if (i == 6) begin
          start8 = 1'b0;
        end
      end else begin
        chk("fin_done", done8, 1);
        chk("fin_diff", diff8, e[7:0]);
        chk("fin_borrow", borrow8, e[8]);
        chk("fin_busy", busy8, 0);
        void'(exp_q.pop_front());
      end
    end
    start8 = 1'b0;
  endtask

  task automatic idle_check8(input string tag);
    @(negedge CK);
    chk({tag, "_done"}, done8, 0);
    chk({tag, "_valid"}, diff_valid8, 0);
    chk({tag, "_busy"}, busy8, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [8:0] e;
    // Reset values appear with no clock edge yet.
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_bit", diff_bit8, 0);
    chk("rst_valid", diff_valid8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_borrow", borrow8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff4", diff4, 0);
    @(negedge CK);
    RST = 1'b0;
    @(negedge CK);

    // Reference vectors, back-to-back.
    op8(8'h5A, 8'h23, 1'b0);
    op8(8'h23, 8'h5A, 1'b0);
    op8(8'h00, 8'h01, 1'b0);
    idle_check8("idle1");

    // Disturbance during RUN, then confirm no extra done.
    op8(8'h80, 8'h80, 1'b1);
    idle_check8("nodup");
    idle_check8("nodup2");

    // start held high: restarts every 9 cycles.
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    for (int k = 0; k < 27; k++) begin
      @(negedge CK);
      chk($sformatf("hold%0d_done", k), done8, (k % 9 == 8) ? 1 : 0);
      chk($sformatf("hold%0d_busy", k), busy8, (k % 9 == 8) ? 0 : 1);
      if (k % 9 == 8) chk($sformatf("hold%0d_diff", k), diff8, 8'h0F);
      if (k == 26) start8 = 1'b0;
    end
    idle_check8("hold_end");

    // Asynchronous reset mid-operation.
    a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
    start8 = 1'b1;
    @(negedge CK);
    start8 = 1'b0;
    repeat (4) @(negedge CK);
    #2 RST = 1'b1;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_bit", diff_bit8, 0);
    chk("arst_valid", diff_valid8, 0);
    chk("arst_diff", diff8, 0);
    chk("arst_borrow", borrow8, 0);
    chk("arst_done", done8, 0);
    @(negedge CK);
    RST = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CK);
      chk($sformatf("post_rst%0d_done", k), done8, 0);
    end
    op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);

    // Random operations, back-to-back.
    repeat (20) op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    idle_check8("rand_end");

    // Exhaustive 4-bit sweep.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        int n;
        a4 = 4'(ai); b4 = 4'(bi); start4 = 1'b1;
        @(negedge CK);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 8) begin
          @(negedge CK);
          n++;
        end
        chk($sformatf("w4_lat_%0d_%0d", ai, bi), n, 4);
        chk($sformatf("w4_diff_%0d_%0d", ai, bi), diff4, ((ai - bi) + 16) % 16);
        chk($sformatf("w4_brw_%0d_%0d", ai, bi), borrow4, (ai < bi) ? 1 : 0);
      end
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: timeout, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
